// File: rtl/subword_dr_seq.sv
// ============================================================================
// Module   : subword_dr_seq (with leaf cell Sbox8b)
// Brief    : Dual-rail AES SubWord engine sharing SBOX_COUNT S-box cells over
//            byte groups, with a precharge spacer before every evaluation.
// Options  : define SUBWORD_RAIL_CHECK_EN for the sticky rail-integrity checker
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module Sbox8b #(
    parameter int LAT = 3
) (
    input  logic [7:0] i_t,
    input  logic [7:0] i_f,
    input  logic [1:0] i_multi_cycle,
    input  logic       i_flipflpoindicator,
    output logic [7:0] o_t,
    output logic [7:0] o_f
);
    localparam logic [1:0] c_LAST = 2'(LAT - 1);

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // GF(2^8) inverse as a^254, then the AES affine transform
    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = f_gmul(p, p);
            inv = f_gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic w_fire;
    assign w_fire = i_flipflpoindicator && (i_multi_cycle == c_LAST);
    assign o_t    = w_fire ? f_sbox(i_t) : 8'h00;
    assign o_f    = w_fire ? ~f_sbox(~i_f) : 8'h00;
endmodule

module subword_dr_seq #(
    parameter int BYTE       = 8,
    parameter int WORD_BYTES = 4,
    parameter int SBOX_COUNT = 2,
    parameter int SBOX_LAT   = 3
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [BYTE*WORD_BYTES-1:0] In_Word_T,
    input  logic [BYTE*WORD_BYTES-1:0] In_Word_F,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [BYTE*WORD_BYTES-1:0] Out_Word_T,
    output logic [BYTE*WORD_BYTES-1:0] Out_Word_F,
    output logic                       Busy,
    output logic                       Rail_Error
);
    localparam int c_W   = BYTE * WORD_BYTES;
    localparam int c_G   = WORD_BYTES / SBOX_COUNT;
    localparam int c_GW  = BYTE * SBOX_COUNT;
    localparam int c_GIW = (c_G > 1) ? $clog2(c_G) : 1;
    localparam logic [1:0]       c_LAST  = 2'(SBOX_LAT - 1);
    localparam logic [c_GIW-1:0] c_GLAST = c_GIW'(c_G - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PRE  = 2'd1;
    localparam logic [1:0] c_EVAL = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic [1:0]       r_state;
    logic [c_GIW-1:0] r_grp;
    logic [1:0]       r_cnt;
    logic [c_W-1:0]   r_in_t, r_in_f, r_res_t, r_res_f;
    logic [c_GW-1:0]  w_grp_t, w_grp_f;
    logic [c_GW-1:0]  w_sbox_in_t, w_sbox_in_f, w_sbox_out_t, w_sbox_out_f;
    logic [1:0]       w_sbox_mc;
    logic             w_sbox_ffi;
    logic             w_accept, w_capture;

    assign In_Ready   = (r_state == c_IDLE);
    assign Busy       = (r_state != c_IDLE);
    assign Out_Valid  = (r_state == c_OUT);
    // Partial results never leave the block
    assign Out_Word_T = Out_Valid ? r_res_t : '0;
    assign Out_Word_F = Out_Valid ? r_res_f : '0;
    assign w_accept   = In_Valid && In_Ready;
    assign w_capture  = (r_state == c_EVAL) && (r_cnt == c_LAST);

    always_comb begin
        w_grp_t = '0;
        w_grp_f = '0;
        for (int g = 0; g < c_G; g++) begin
            if (r_grp == c_GIW'(g)) begin
                w_grp_t = r_in_t[g*c_GW +: c_GW];
                w_grp_f = r_in_f[g*c_GW +: c_GW];
            end
        end
    end

    // Outside EVAL the shared cells see the all-zero spacer
    assign w_sbox_ffi  = (r_state == c_EVAL);
    assign w_sbox_in_t = w_sbox_ffi ? w_grp_t : '0;
    assign w_sbox_in_f = w_sbox_ffi ? w_grp_f : '0;
    assign w_sbox_mc   = w_sbox_ffi ? r_cnt : 2'd0;

    for (genvar gi = 0; gi < SBOX_COUNT; gi++) begin : g_sbox
        Sbox8b #(.LAT(SBOX_LAT)) u_sbox (
            .i_t                 (w_sbox_in_t[gi*BYTE +: BYTE]),
            .i_f                 (w_sbox_in_f[gi*BYTE +: BYTE]),
            .i_multi_cycle       (w_sbox_mc),
            .i_flipflpoindicator (w_sbox_ffi),
            .o_t                 (w_sbox_out_t[gi*BYTE +: BYTE]),
            .o_f                 (w_sbox_out_f[gi*BYTE +: BYTE])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_grp   <= '0;
            r_cnt   <= 2'd0;
            r_in_t  <= '0;
            r_in_f  <= '0;
            r_res_t <= '0;
            r_res_f <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_in_t  <= In_Word_T;
                        r_in_f  <= In_Word_F;
                        r_grp   <= '0;
                        r_state <= c_PRE;
                    end
                end
                c_PRE: begin
                    r_cnt   <= 2'd0;
                    r_state <= c_EVAL;
                end
                c_EVAL: begin
                    if (w_capture) begin
                        for (int g = 0; g < c_G; g++) begin
                            if (r_grp == c_GIW'(g)) begin
                                r_res_t[g*c_GW +: c_GW] <= w_sbox_out_t;
                                r_res_f[g*c_GW +: c_GW] <= w_sbox_out_f;
                            end
                        end
                        r_cnt <= 2'd0;
                        if (r_grp == c_GLAST) begin
                            r_state <= c_OUT;
                        end else begin
                            r_grp   <= r_grp + 1'b1;
                            r_state <= c_PRE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                c_OUT: begin
                    if (Out_Ready) begin
                        r_state <= c_IDLE;
                        r_in_t  <= '0;
                        r_in_f  <= '0;
                        r_res_t <= '0;
                        r_res_f <= '0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef SUBWORD_RAIL_CHECK_EN
    logic r_rail_err;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rail_err <= 1'b0;
        end else if (w_accept && (|(In_Word_T ~^ In_Word_F))) begin
            r_rail_err <= 1'b1;
        end else if (w_capture && (|(w_sbox_out_t ~^ w_sbox_out_f))) begin
            r_rail_err <= 1'b1;
        end
    end
    assign Rail_Error = r_rail_err;
`else
    assign Rail_Error = 1'b0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_subword_dr_seq.sv
// ============================================================================
// Module   : tb_subword_dr_seq
// Brief    : Self-checking bench for subword_dr_seq against a table-based
//            AES S-box reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subword_dr_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy, rail_err;
    logic [31:0] in_t, in_f, out_t, out_f;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8, rail_err8;
    logic [63:0] in_t8, in_f8, out_t8, out_f8;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sbox_tab [256];

    subword_dr_seq #(.BYTE(8), .WORD_BYTES(4), .SBOX_COUNT(2), .SBOX_LAT(3)) dut (
        .Clk(clk), .Reset(reset), .In_Valid(in_valid), .In_Ready(in_ready),
        .In_Word_T(in_t), .In_Word_F(in_f), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Out_Word_T(out_t), .Out_Word_F(out_f), .Busy(busy), .Rail_Error(rail_err));

    subword_dr_seq #(.BYTE(8), .WORD_BYTES(8), .SBOX_COUNT(8), .SBOX_LAT(1)) dut8 (
        .Clk(clk), .Reset(reset), .In_Valid(in_valid8), .In_Ready(in_ready8),
        .In_Word_T(in_t8), .In_Word_F(in_f8), .Out_Valid(out_valid8), .Out_Ready(out_ready8),
        .Out_Word_T(out_t8), .Out_Word_F(out_f8), .Busy(busy8), .Rail_Error(rail_err8));

    always #5 clk = ~clk;

`ifdef SUBWORD_RAIL_CHECK_EN
    localparam logic c_RAIL_EXP = 1'b1;
`else
    localparam logic c_RAIL_EXP = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = xtime(x);
        end
        return r;
    endfunction

    // Reference S-box: brute-force inverse search plus bitwise affine map
    task automatic build_sbox();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [63:0] sub_word(input logic [63:0] w, input int nb);
        logic [63:0] r = '0;
        for (int b = 0; b < nb; b++) r[b*8 +: 8] = sbox_tab[w[b*8 +: 8]];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] t, input logic [31:0] f);
        in_t = t; in_f = f; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || rail_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: rdy=%b busy=%b vld=%b rerr=%b required 1 0 0 0", in_ready, busy, out_valid, rail_err);
        end
        checks++;
        if (out_t !== 32'h0 || out_f !== 32'h0 || in_ready8 !== 1'b1 || out_t8 !== 64'h0) begin
            failures++;
            $display("FAIL reset_data: out_t=%h out_f=%h rdy8=%b out_t8=%h required zeros/1", out_t, out_f, in_ready8, out_t8);
        end
        reset = 1'b0;
    endtask

    task automatic test_vector();
        int n = 0;
        out_ready = 1'b1;
        send(32'h53020100, 32'hACFDFEFF);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL vec_busy: rdy=%b busy=%b required 0 1", in_ready, busy);
        end
        while (!out_valid && n < 100) begin
            checks++;
            if (out_t !== 32'h0 || out_f !== 32'h0) begin
                failures++;
                $display("FAIL vec_leak: out_t=%h out_f=%h required 0 before valid", out_t, out_f);
            end
            step();
            n++;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL vec_latency: edges=%0d required 8", n);
        end
        checks++;
        if (out_t !== 32'hED777C63 || out_f !== 32'h1288839C || rail_err !== 1'b0) begin
            failures++;
            $display("FAIL vec_data: t=%h f=%h rerr=%b required ED777C63 1288839C 0", out_t, out_f, rail_err);
        end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 16; k++) begin
            logic [31:0] t = $urandom;
            logic [31:0] exp_t = sub_word({32'h0, t}, 4);
            int n;
            int hold = $urandom_range(0, 3);
            out_ready = 1'b0;
            send(t, ~t);
            wait_out(n);
            checks++;
            if (n != 8 || out_t !== exp_t || out_f !== ~exp_t) begin
                failures++;
                $display("FAIL rand_%0d: edges=%0d t=%h f=%h required 8 %h %h", k, n, out_t, out_f, exp_t, ~exp_t);
            end
            for (int h = 0; h < hold; h++) step();
            out_ready = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_done_%0d: vld=%b rdy=%b required 0 1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] t = $urandom;
        logic [31:0] exp_t = sub_word({32'h0, t}, 4);
        out_ready = 1'b0;
        send(t, ~t);
        wait_out(n);
        for (int h = 0; h < 5; h++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_t !== exp_t || out_f !== ~exp_t) begin
                failures++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b t=%h f=%h required 1 0 %h %h", h, out_valid, in_ready, out_t, out_f, exp_t, ~exp_t);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_t !== 32'h0 || out_f !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: vld=%b t=%h f=%h rdy=%b required 0 0 0 1", out_valid, out_t, out_f, in_ready);
        end
    endtask

    task automatic test_precharge();
        logic [31:0] t = $urandom;
        out_ready = 1'b0;
        send(t, ~t);
        for (int j = 0; j < 8; j++) begin
            int phase = j % 4;
            logic [31:0] sh_t = t >> ((j / 4) * 16);
            logic [31:0] sh_f = ~t >> ((j / 4) * 16);
            checks++;
            if (phase == 0) begin
                if (dut.w_sbox_in_t !== 16'h0 || dut.w_sbox_in_f !== 16'h0 || dut.w_sbox_ffi !== 1'b0) begin
                    failures++;
                    $display("FAIL pre_%0d: in_t=%h in_f=%h ffi=%b required 0 0 0", j, dut.w_sbox_in_t, dut.w_sbox_in_f, dut.w_sbox_ffi);
                end
            end else begin
                if (dut.w_sbox_in_t !== sh_t[15:0] || dut.w_sbox_in_f !== sh_f[15:0] ||
                    dut.w_sbox_ffi !== 1'b1 || dut.w_sbox_mc !== 2'(phase - 1)) begin
                    failures++;
                    $display("FAIL eval_%0d: in_t=%h in_f=%h ffi=%b mc=%0d required %h %h 1 %0d", j,
                             dut.w_sbox_in_t, dut.w_sbox_in_f, dut.w_sbox_ffi, dut.w_sbox_mc, sh_t[15:0], sh_f[15:0], phase - 1);
                end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_end: vld=%b required 1", out_valid);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom;
        logic [31:0] exp_b = sub_word({32'h0, b}, 4);
        out_ready = 1'b1;
        in_t = a; in_f = ~a; in_valid = 1'b1;
        step();
        wait_out(n);
        in_t = b; in_f = ~b;
        checks++;
        if (n != 8 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_out: edges=%0d rdy=%b required 8 0", n, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        wait_out(n);
        checks++;
        if (n != 8 || out_t !== exp_b || out_f !== ~exp_b) begin
            failures++;
            $display("FAIL b2b_second: edges=%0d t=%h f=%h required 8 %h %h", n, out_t, out_f, exp_b, ~exp_b);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int n;
        logic [31:0] t = $urandom;
        logic [31:0] exp_t = sub_word({32'h0, t}, 4);
        out_ready = 1'b1;
        send($urandom, $urandom);
        for (int s = 0; s < 5; s++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_t !== 32'h0 || out_f !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: rdy=%b busy=%b vld=%b t=%h f=%h required 1 0 0 0 0", in_ready, busy, out_valid, out_t, out_f);
        end
        for (int s = 0; s < 10; s++) step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_quiet: vld=%b busy=%b required 0 0", out_valid, busy);
        end
        send(t, ~t);
        wait_out(n);
        checks++;
        if (n != 8 || out_t !== exp_t || out_f !== ~exp_t) begin
            failures++;
            $display("FAIL mid_reset_fresh: edges=%0d t=%h f=%h required 8 %h %h", n, out_t, out_f, exp_t, ~exp_t);
        end
        step();
    endtask

    task automatic test_wide();
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            logic [63:0] t = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            logic [63:0] exp_t = sub_word(t, 8);
            in_t8 = t; in_f8 = ~t; in_valid8 = 1'b1;
            step();
            in_valid8 = 1'b0;
            while (!out_valid8 && n < 100) begin
                step();
                n++;
            end
            checks++;
            if (n != 2 || out_t8 !== exp_t || out_f8 !== ~exp_t) begin
                failures++;
                $display("FAIL wide_%0d: edges=%0d t=%h f=%h required 2 %h %h", k, n, out_t8, out_f8, exp_t, ~exp_t);
            end
            step();
        end
    endtask

    task automatic test_rail();
        int n;
        out_ready = 1'b1;
        send(32'h00000001, 32'hFFFFFFFF);
        checks++;
        if (rail_err !== c_RAIL_EXP) begin
            failures++;
            $display("FAIL rail_set: rerr=%b required %b", rail_err, c_RAIL_EXP);
        end
        wait_out(n);
        step();
        send(32'h12345678, ~32'h12345678);
        wait_out(n);
        step();
        checks++;
        if (rail_err !== c_RAIL_EXP) begin
            failures++;
            $display("FAIL rail_sticky: rerr=%b required %b", rail_err, c_RAIL_EXP);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (rail_err !== 1'b0) begin
            failures++;
            $display("FAIL rail_clear: rerr=%b required 0", rail_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_t = '0; in_f = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_t8 = '0; in_f8 = '0; out_ready8 = 1'b1;
        build_sbox();
        test_reset();
        test_vector();
        test_random();
        test_backpressure();
        test_precharge();
        test_back_to_back();
        test_mid_reset();
        test_wide();
        test_rail();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
